// File: rtl/up_core_p_pkg.sv
// up_core_pkg: opcodes, FSM encoding and instruction-slicing helpers shared by the up_core_p slice
package up_core_pkg;
  localparam int MAX_AW = 16;
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LIT   = 4'd1;
  localparam logic [3:0] OP_IN    = 4'd2;
  localparam logic [3:0] OP_LD    = 4'd3;
  localparam logic [3:0] OP_ST    = 4'd4;
  localparam logic [3:0] OP_ADDI  = 4'd5;
  localparam logic [3:0] OP_ADDM  = 4'd6;
  localparam logic [3:0] OP_SUBI  = 4'd7;
  localparam logic [3:0] OP_SUBM  = 4'd8;
  localparam logic [3:0] OP_NANDI = 4'd9;
  localparam logic [3:0] OP_JMP   = 4'd10;
  localparam logic [3:0] OP_JC    = 4'd11;
  localparam logic [3:0] OP_JZ    = 4'd12;
  localparam logic [3:0] OP_CALL  = 4'd13;
  localparam logic [3:0] OP_RET   = 4'd14;
  localparam logic [3:0] OP_OUT   = 4'd15;
  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;
  // words arrive zero-extended to the widest supported address width
  function automatic logic [3:0] instr_op(input logic [MAX_AW+3:0] w, input int aw);
    return w[aw +: 4];
  endfunction
  function automatic logic [MAX_AW-1:0] instr_field(input logic [MAX_AW+3:0] w, input int aw);
    return w[MAX_AW-1:0] & ((MAX_AW'(1) << aw) - MAX_AW'(1));
  endfunction
  function automatic logic is_mem(input logic [3:0] op);
    return op inside {OP_LD, OP_ST, OP_ADDM, OP_SUBM};
  endfunction
endpackage

// File: rtl/up_core_p_if.sv
// up_core_p_if: program-ROM fetch bus and ready-handshaked data-RAM bus of the core
interface up_core_p_if #(parameter int DATA_W = 4, parameter int ADDR_W = 12);
  logic [ADDR_W-1:0] prog_addr;
  logic [ADDR_W+3:0] prog_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic ram_req;
  logic ram_we;
  logic ram_ready;
  modport master (output prog_addr, ram_addr, ram_wdata, ram_req, ram_we,
                  input prog_data, ram_rdata, ram_ready);
  modport slave (input prog_addr, ram_addr, ram_wdata, ram_req, ram_we,
                 output prog_data, ram_rdata, ram_ready);
endinterface

// File: rtl/up_core_p_stack.sv
// up_core_stack: return-address LIFO; pushes when full and pops when empty are ignored
module up_core_stack #(parameter int WIDTH = 12, parameter int DEPTH = 4) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0] sp;
  assign full = sp == (PW+1)'(DEPTH);
  assign empty = sp == '0;
  assign dout = mem[PW'(sp - (PW+1)'(1))];
  always_ff @(posedge clock or negedge reset)
    if (!reset) sp <= '0;
    else if (push && !full) sp <= sp + (PW+1)'(1);
    else if (pop && !empty) sp <= sp - (PW+1)'(1);
  always_ff @(posedge clock)
    if (push && !full) mem[PW'(sp)] <= din;
endmodule

// File: rtl/up_core_p.sv
// up_core_p: two-phase accumulator core with external ROM/RAM, wait-state RAM handshake and return stack
module up_core_p
  import up_core_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  up_core_p_if.master       bus,
  input  logic [DATA_W-1:0] pushbuttons,
  output logic [DATA_W-1:0] out_port,
  output logic              phase,
  output logic              c_flag,
  output logic              z_flag,
  output logic [DATA_W-1:0] accu,
  output logic [ADDR_W-1:0] pc,
  output logic              stk_err
);
  logic rst_meta, rst_n;
  state_t state, state_nx;
  logic [ADDR_W+3:0] ir;
  logic [MAX_AW+3:0] ir_w;
  logic [3:0] op;
  logic [ADDR_W-1:0] field, pc_inc, pc_nx, ret_addr;
  logic [DATA_W-1:0] imm, opnd, accu_nx;
  logic [DATA_W:0] alu;
  logic mem_op, done, flag_we, push, pop, full, empty;
  // reset asserts asynchronously but leaves the core only on a clock edge
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rst_meta <= 1'b0;
      rst_n <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n <= rst_meta;
    end
  assign ir_w = (MAX_AW+4)'(ir);
  assign op = instr_op(ir_w, ADDR_W);
  assign field = ADDR_W'(instr_field(ir_w, ADDR_W));
  assign imm = field[DATA_W-1:0];
  assign mem_op = is_mem(op);
  assign pc_inc = pc + ADDR_W'(1);
  assign bus.prog_addr = pc;
  assign bus.ram_addr = field;
  assign bus.ram_wdata = accu;
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else state <= state_nx;
  always_comb state_nx = (state == FETCH) ? EXEC : (done ? FETCH : EXEC);
  always_comb begin
    phase = state == EXEC;
    bus.ram_req = rst_n && phase && mem_op;
    bus.ram_we = op == OP_ST;
    done = phase && (!mem_op || bus.ram_ready);
  end
  assign opnd = (op == OP_ADDM || op == OP_SUBM) ? bus.ram_rdata : imm;
  assign flag_we = op inside {OP_ADDI, OP_ADDM, OP_SUBI, OP_SUBM, OP_NANDI};
  always_comb
    alu = (op == OP_ADDI || op == OP_ADDM) ? {1'b0, accu} + {1'b0, opnd} :
          (op == OP_SUBI || op == OP_SUBM) ? {1'b0, accu} - {1'b0, opnd} :
          {1'b0, ~(accu & imm)};
  always_comb
    accu_nx = (op == OP_LIT) ? imm :
              (op == OP_IN)  ? pushbuttons :
              (op == OP_LD)  ? bus.ram_rdata :
              flag_we        ? alu[DATA_W-1:0] : accu;
  always_comb
    pc_nx = (op == OP_JMP || op == OP_CALL)                  ? field :
            ((op == OP_JC && c_flag) || (op == OP_JZ && z_flag)) ? field :
            (op == OP_RET && !empty)                         ? ret_addr : pc_inc;
  assign push = done && op == OP_CALL && !full;
  assign pop = done && op == OP_RET && !empty;
  up_core_stack #(.WIDTH(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clock(clock),
    .reset(rst_n),
    .push(push),
    .pop(pop),
    .din(pc_inc),
    .dout(ret_addr),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      ir <= '0;
      pc <= '0;
      accu <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
      out_port <= '0;
      stk_err <= 1'b0;
    end else if (state == FETCH) begin
      ir <= bus.prog_data;
    end else if (done) begin
      pc <= pc_nx;
      accu <= accu_nx;
      if (flag_we) begin
        c_flag <= alu[DATA_W];
        z_flag <= alu[DATA_W-1:0] == '0;
      end
      if (op == OP_OUT) out_port <= accu;
      if ((op == OP_CALL && full) || (op == OP_RET && empty)) stk_err <= 1'b1;
    end
endmodule

// File: tb/tb_up_core_p.sv
// tb_up_core_p: table-driven program run on a 4/12 core plus reset and 8/16 wrap sequences
module tb_up_core_p;
  import up_core_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1, rst2_n = 1'b1;
  always #5 clk = ~clk;

  up_core_p_if #(.DATA_W(4), .ADDR_W(12)) bus ();
  logic [3:0] pb = 4'hA, out_port, accu;
  logic phase, c_flag, z_flag, stk_err;
  logic [11:0] pc;
  up_core_p #(.DATA_W(4), .ADDR_W(12), .STACK_DEPTH(4)) dut (
    .clock(clk), .reset(rst_n), .bus(bus), .pushbuttons(pb), .out_port(out_port),
    .phase(phase), .c_flag(c_flag), .z_flag(z_flag), .accu(accu), .pc(pc), .stk_err(stk_err));

  up_core_p_if #(.DATA_W(8), .ADDR_W(16)) bus2 ();
  logic [7:0] pb2 = 8'h00, out2, accu2;
  logic phase2, c2, z2, err2;
  logic [15:0] pc2;
  up_core_p #(.DATA_W(8), .ADDR_W(16), .STACK_DEPTH(4)) dut2 (
    .clock(clk), .reset(rst2_n), .bus(bus2), .pushbuttons(pb2), .out_port(out2),
    .phase(phase2), .c_flag(c2), .z_flag(z2), .accu(accu2), .pc(pc2), .stk_err(err2));

  logic [15:0] rom [4096];
  logic [3:0] ram [4096];
  int wait_cfg = 0, wcnt = 0;
  assign bus.prog_data = rom[bus.prog_addr];
  assign bus.ram_ready = bus.ram_req && wcnt == wait_cfg;
  assign bus.ram_rdata = ram[bus.ram_addr];
  always @(posedge clk) begin
    if (bus.ram_req && bus.ram_ready && bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    wcnt <= (!bus.ram_req || bus.ram_ready) ? 0 : wcnt + 1;
  end
  always_comb
    case (bus2.prog_addr)
      16'h0000: bus2.prog_data = {OP_LIT, 16'h00FF};
      16'h0001: bus2.prog_data = {OP_ADDI, 16'h0001};
      16'h0002: bus2.prog_data = {OP_JMP, 16'hFFFF};
      default:  bus2.prog_data = {OP_NOP, 16'h0000};
    endcase
  assign bus2.ram_ready = 1'b0;
  assign bus2.ram_rdata = 8'h00;

  typedef struct {
    logic [15:0] ins;
    int waits, cyc;
    logic [3:0] a;
    logic c, z;
    logic [11:0] pc;
    logic [3:0] o;
    logic err;
  } vec_t;
  vec_t v[$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [11:0] f, input int w, input int cy,
                     input logic [3:0] a, input logic c, input logic z, input logic [11:0] p,
                     input logic [3:0] o, input logic e);
    vec_t r;
    r.ins = {op, f}; r.waits = w; r.cyc = cy; r.a = a; r.c = c; r.z = z;
    r.pc = p; r.o = o; r.err = e;
    v.push_back(r);
  endtask

  // one instruction from a FETCH negedge to the next FETCH negedge, checking the RAM bus while held
  task automatic step(input string tag, input logic [15:0] ins, input logic [3:0] a_prev, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (phase && is_mem(ins[15:12])) begin
        chk($sformatf("%s ram_req", tag), bus.ram_req, 1);
        chk($sformatf("%s ram_we", tag), bus.ram_we, ins[15:12] == OP_ST);
        chk($sformatf("%s ram_addr", tag), bus.ram_addr, ins[11:0]);
        chk($sformatf("%s ram_wdata", tag), bus.ram_wdata, a_prev);
      end
    end while (phase && cyc < 20);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    logic [11:0] cur;
    logic [3:0] a_prev;
    add(OP_LIT,   12'h005, 0, 2, 4'h5, 0, 0, 12'h001, 4'h0, 0);
    add(OP_ADDI,  12'h003, 0, 2, 4'h8, 0, 0, 12'h002, 4'h0, 0);
    add(OP_OUT,   12'h000, 0, 2, 4'h8, 0, 0, 12'h003, 4'h8, 0);
    add(OP_LIT,   12'h00F, 0, 2, 4'hF, 0, 0, 12'h004, 4'h8, 0);
    add(OP_ADDI,  12'h001, 0, 2, 4'h0, 1, 1, 12'h005, 4'h8, 0);
    add(OP_JC,    12'h040, 0, 2, 4'h0, 1, 1, 12'h040, 4'h8, 0);
    add(OP_LIT,   12'h003, 0, 2, 4'h3, 1, 1, 12'h041, 4'h8, 0);
    add(OP_SUBI,  12'h005, 0, 2, 4'hE, 1, 0, 12'h042, 4'h8, 0);
    add(OP_NANDI, 12'h00E, 0, 2, 4'h1, 0, 0, 12'h043, 4'h8, 0);
    add(OP_JZ,    12'h000, 0, 2, 4'h1, 0, 0, 12'h044, 4'h8, 0);
    add(OP_JC,    12'h000, 0, 2, 4'h1, 0, 0, 12'h045, 4'h8, 0);
    add(OP_SUBI,  12'h001, 0, 2, 4'h0, 0, 1, 12'h046, 4'h8, 0);
    add(OP_JZ,    12'h050, 0, 2, 4'h0, 0, 1, 12'h050, 4'h8, 0);
    add(OP_IN,    12'h000, 0, 2, 4'hA, 0, 1, 12'h051, 4'h8, 0);
    add(OP_ADDI,  12'h006, 0, 2, 4'h0, 1, 1, 12'h052, 4'h8, 0);
    add(OP_NANDI, 12'h00F, 0, 2, 4'hF, 0, 0, 12'h053, 4'h8, 0);
    add(OP_NOP,   12'h000, 0, 2, 4'hF, 0, 0, 12'h054, 4'h8, 0);
    add(OP_ST,    12'h123, 3, 5, 4'hF, 0, 0, 12'h055, 4'h8, 0);
    add(OP_LIT,   12'h000, 0, 2, 4'h0, 0, 0, 12'h056, 4'h8, 0);
    add(OP_LD,    12'h123, 0, 2, 4'hF, 0, 0, 12'h057, 4'h8, 0);
    add(OP_ADDM,  12'h200, 1, 3, 4'h2, 1, 0, 12'h058, 4'h8, 0);
    add(OP_SUBM,  12'h201, 2, 4, 4'h0, 0, 1, 12'h059, 4'h8, 0);
    add(OP_SUBM,  12'h200, 0, 2, 4'hD, 1, 0, 12'h05A, 4'h8, 0);
    add(OP_CALL,  12'h100, 0, 2, 4'hD, 1, 0, 12'h100, 4'h8, 0);
    add(OP_CALL,  12'h110, 0, 2, 4'hD, 1, 0, 12'h110, 4'h8, 0);
    add(OP_CALL,  12'h120, 0, 2, 4'hD, 1, 0, 12'h120, 4'h8, 0);
    add(OP_CALL,  12'h130, 0, 2, 4'hD, 1, 0, 12'h130, 4'h8, 0);
    add(OP_CALL,  12'h140, 0, 2, 4'hD, 1, 0, 12'h140, 4'h8, 1);
    add(OP_RET,   12'h000, 0, 2, 4'hD, 1, 0, 12'h121, 4'h8, 1);
    add(OP_RET,   12'h000, 0, 2, 4'hD, 1, 0, 12'h111, 4'h8, 1);
    add(OP_RET,   12'h000, 0, 2, 4'hD, 1, 0, 12'h101, 4'h8, 1);
    add(OP_RET,   12'h000, 0, 2, 4'hD, 1, 0, 12'h05B, 4'h8, 1);
    add(OP_RET,   12'h000, 0, 2, 4'hD, 1, 0, 12'h05C, 4'h8, 1);
    add(OP_OUT,   12'h000, 0, 2, 4'hD, 1, 0, 12'h05D, 4'hD, 1);
    add(OP_JMP,   12'hFFF, 0, 2, 4'hD, 1, 0, 12'hFFF, 4'hD, 1);
    add(OP_NOP,   12'h000, 0, 2, 4'hD, 1, 0, 12'h000, 4'hD, 1);
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 16'h0000;
      ram[i] = 4'h0;
    end
    ram[12'h200] = 4'h3;
    ram[12'h201] = 4'h2;
    cur = 12'h000;
    foreach (v[i]) begin
      rom[cur] = v[i].ins;
      cur = v[i].pc;
    end

    #1 rst_n = 1'b0; rst2_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset accu", accu, 0);
    chk("reset pc", pc, 0);
    chk("reset out_port", out_port, 0);
    chk("reset flags", {c_flag, z_flag}, 0);
    chk("reset stk_err", stk_err, 0);
    chk("reset phase", phase, 0);
    chk("reset ram_req", bus.ram_req, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < v.size(); i++) begin
      a_prev = (i == 0) ? 4'h0 : v[i-1].a;
      wait_cfg = v[i].waits;
      step($sformatf("row%0d", i), v[i].ins, a_prev, cyc);
      chk($sformatf("row%0d cycles", i), cyc, v[i].cyc);
      chk($sformatf("row%0d accu", i), accu, v[i].a);
      chk($sformatf("row%0d c_flag", i), c_flag, v[i].c);
      chk($sformatf("row%0d z_flag", i), z_flag, v[i].z);
      chk($sformatf("row%0d pc", i), pc, v[i].pc);
      chk($sformatf("row%0d prog_addr", i), bus.prog_addr, v[i].pc);
      chk($sformatf("row%0d out_port", i), out_port, v[i].o);
      chk($sformatf("row%0d stk_err", i), stk_err, v[i].err);
    end
    chk("ram[0x123] after ST", ram[12'h123], 4'hF);

    // reset asserted while SUBM is stalled on wait states
    rom[0] = {OP_SUBM, 12'h201};
    wait_cfg = 10;
    repeat (2) @(negedge clk);
    chk("midreset pre ram_req", bus.ram_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset ram_req", bus.ram_req, 0);
    chk("midreset phase", phase, 0);
    chk("midreset accu", accu, 0);
    chk("midreset pc", pc, 0);
    chk("midreset flags", {c_flag, z_flag}, 0);
    chk("midreset out_port", out_port, 0);
    chk("midreset stk_err", stk_err, 0);
    chk("midreset prog_addr", bus.prog_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cfg = 0;
    rom[0] = {OP_LIT, 12'h005};
    repeat (2) @(negedge clk);
    chk("restart ram_req", bus.ram_req, 0);
    step("restart", rom[0], 4'h0, cyc);
    chk("restart cycles", cyc, 2);
    chk("restart accu", accu, 4'h5);
    chk("restart pc", pc, 12'h001);

    // 8-bit data, 16-bit address instance: carry out of 0xFF and PC wrap
    rst2_n = 1'b1;
    repeat (2) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("w8 LIT accu", accu2, 8'hFF);
    chk("w8 LIT pc", pc2, 16'h0001);
    repeat (2) @(negedge clk);
    chk("w8 ADDI accu", accu2, 8'h00);
    chk("w8 ADDI c_flag", c2, 1);
    chk("w8 ADDI z_flag", z2, 1);
    repeat (2) @(negedge clk);
    chk("w8 JMP pc", pc2, 16'hFFFF);
    repeat (2) @(negedge clk);
    chk("w8 NOP wrap pc", pc2, 16'h0000);
    chk("w8 prog_addr", bus2.prog_addr, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/up_core_p.md
# up_core_p

Parametrised accumulator microprocessor core, the successor to the fixed 4-bit nibble processor. It keeps the same accumulator, ALU, flags and program-counter organisation. Generalisations:
- data and address widths are parameters;
- program and data memories move outside the core;
- data-memory accesses use a ready handshake (wait states);
- a hardware return stack supports CALL/RET.

It sits between an external program ROM, an external data RAM and the board I/O (pushbuttons in, registered output port out).

## Interface
Parameters:
- DATA_W, 4, accumulator, ALU and data-bus width (2..16)
- ADDR_W, 12, PC and RAM address width; must satisfy ADDR_W >= DATA_W
- STACK_DEPTH, 4, return-stack entries (power of two, >= 2)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; one clock, async active-low reset, no other reset
- prog_addr  out  ADDR_W  program address (= PC)
- prog_data  in  4+ADDR_W  instruction word, combinational from prog_addr
- ram_addr  out  ADDR_W  data address (= instruction field)
- ram_wdata  out  DATA_W  store data (= accumulator)
- ram_req  out  1  data access request
- ram_we  out  1  1 = write, 0 = read; valid while ram_req
- ram_rdata  in  DATA_W  read data, sampled in the ram_ready cycle
- ram_ready  in  1  access completes this cycle
- pushbuttons  in  DATA_W  input port
- out_port  out  DATA_W  registered output port
- phase  out  1  0 = FETCH, 1 = EXEC
- c_flag, z_flag  out  1  carry/borrow and zero flags
- accu  out  DATA_W  accumulator
- pc  out  ADDR_W  program counter
- stk_err  out  1  sticky stack overflow/underflow

## Operation
Instruction word layout:
- {op[3:0], field[ADDR_W-1:0]}
- imm = field[DATA_W-1:0]

Opcodes (flag writes marked F):
- 0 NOP
- 1 LIT: A=imm
- 2 IN: A=pushbuttons
- 3 LD: A=mem[field]
- 4 ST: mem[field]=A
- 5 ADDI: A=A+imm (F)
- 6 ADDM: A=A+mem (F)
- 7 SUBI: A=A-imm (F)
- 8 SUBM: A=A-mem (F)
- 9 NANDI: A=~(A&imm) (F)
- 10 JMP: PC=field
- 11 JC: jump if c_flag
- 12 JZ: jump if z_flag
- 13 CALL: push PC+1, PC=field
- 14 RET: PC=pop
- 15 OUT: out_port=A

Arithmetic and flags:
- ALU result is DATA_W+1 bits.
- c_flag = bit DATA_W. For SUB this is the borrow, set when A < operand.
- z_flag = result[DATA_W-1:0] == 0.
- NANDI forces c_flag to 0.
- Only opcodes marked F write the flags.
- PC wraps modulo 2^ADDR_W.

Memory ops (LD, ST, ADDM, SUBM):
- ram_req=1 throughout EXEC. ram_addr, ram_we and ram_wdata are held stable until ram_ready.
- Zero-wait access when ram_ready=1 in the first EXEC cycle.

Return stack:
- Overflow: CALL with the stack full sets stk_err; the jump still happens, the push is dropped.
- Underflow: RET with the stack empty sets stk_err; PC=PC+1.
- stk_err clears only on reset.

State machine:
- FETCH: instr reg <= prog_data, then go to EXEC.
- EXEC: execute, PC update, then back to FETCH. Memory ops stay in EXEC while ram_req && !ram_ready.

Reset (reset=0, asynchronous):
- PC=0, accu=0, flags=0, out_port=0, SP=0, stk_err=0, instr reg=0, state FETCH.
- ram_req deasserts immediately, mid-access included.
- Reset is released synchronously inside the core.

## Timing
- Non-memory instruction: 2 cycles. Memory instruction: 2 + wait cycles.
- All architectural registers (accu, flags, PC, out_port, SP) update on the rising edge ending the final EXEC cycle.
- JC/JZ sample the flags held before the instruction.
- The prog_addr change is visible in the following FETCH.
- ram_req rises combinationally at EXEC entry and falls after the ram_ready edge.
- ram_ready outside ram_req is ignored.

## Structure
- Package up_core_pkg: opcode localparams, state encoding (FETCH/EXEC), instruction-field slice helpers.
- Sub-module up_core_stack: parametrised LIFO. Ports: clock, reset, push, pop, din, dout, full, empty.
- Everything else (ALU, control, registers) lives in the top module.

## Test plan
- Reset then LIT 5, ADDI 3, OUT, with DATA_W=4: out_port=8, c=0, z=0; each instruction takes 2 cycles.
- With A=0xF, ADDI 1 gives A=0, c=1, z=1, then JC 0x040 gives pc=0x040. With A=3, SUBI 5 gives A=0xE, c=1.
- ST 0x123 with ram_ready held low 3 cycles: ram_req, ram_we=1, addr and data stable for 4 EXEC cycles; next FETCH starts after the ready edge. Zero-wait LD variant: 2 cycles.
- 5 nested CALLs with STACK_DEPTH=4: stk_err=1 after the 5th. 4 RETs return to the correct addresses, and the 5th RET advances PC+1.
- Assert reset mid-wait during SUBM: ram_req drops immediately and all outputs reach their reset values; after release, fetch restarts at pc=0.
- DATA_W=8, ADDR_W=16: LIT 0xFF, ADDI 0x01 gives accu=0x00, c=1; JMP 0xFFFF then NOP wraps pc to 0x0000.
